dcache_mem_responder: RTL and testbench
=======================================

Name: dcache_mem_responder

Overview:
- Memory-side responder for the D-cache line request interface. It accepts whole-line write-back and line-fill requests from the cache miss path (valid/mready request handshake, mvalid/ready response handshake).
- Each line is serialised into 32-bit beats on a simple in-order word bus.
- For reads, the returned words are gathered and delivered to the cache as one 128-bit line.
- Sits between the D-cache miss path and the memory arbiter/bridge.

Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; line is LINE_WORDS*32 bits.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  cache request valid.
- req_wen  in  1  1 = line write-back, 0 = line fill.
- req_addr  in  ADDR_W  line byte address; bits [3:0] ignored (treated as 0).
- req_data  in  128  write-back line; word k = bits [32k+31:32k].
- req_ready  out  1  responder can accept a request (cache's mready).
- resp_valid  out  1  fill line valid (cache's mvalid).
- resp_data  out  128  fill line; word k = bits [32k+31:32k].
- resp_ready  in  1  cache accepts the fill line.
- mem_req  out  1  word-bus request.
- mem_we  out  1  word-bus write.
- mem_addr  out  ADDR_W  word byte address.
- mem_wdata  out  32  write word.
- mem_gnt  in  1  word bus accepts the current beat this cycle.
- mem_rvalid  in  1  read word returned (in order, ≥1 cycle after its grant).
- mem_rdata  in  32  read word.
- err  out  1  sticky: mem_rvalid seen outside READ, or beyond LINE_WORDS.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; counters 0; line buffer 0; err 0.
  - Resulting outputs: req_ready=1, resp_valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_data=0.
- Request handshake:
  - A request is accepted when req_valid & req_ready at a posedge.
  - req_ready = (state==IDLE); it is combinational on state only, with no dependence on req_valid.
  - On accept, latch base={req_addr[ADDR_W-1:4],4'b0}, wen and req_data, and clear icnt (beats issued) and rcnt (words received).
- States:
  - IDLE: accept → WRITE if wen, else READ.
  - WRITE: mem_req=1, mem_we=1, mem_addr=base+4*icnt, mem_wdata=word icnt of latched line. On mem_gnt, icnt++. After the grant of beat LINE_WORDS-1 → IDLE. Writes are posted; no response is generated for them.
  - READ: mem_req=(icnt<LINE_WORDS), mem_we=0, mem_addr=base+4*icnt.
    - On mem_gnt with mem_req=1, icnt++.
    - On mem_rvalid, store mem_rdata into word rcnt and increment rcnt.
    - When the rvalid for word LINE_WORDS-1 arrives → RESP.
    - Grant and rvalid in the same cycle are both processed.
  - RESP: resp_valid=1, resp_data=buffer (stable while waiting). On resp_ready → IDLE.
- Latency:
  - The first mem_req is asserted the cycle after accept.
  - With a zero-wait bus (gnt every cycle, rvalid 1 cycle after gnt), a write takes 4 cycles and a fill presents resp_valid 6 cycles after accept.
- Word-bus rules:
  - mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_gnt=0.
  - mem_req is never dropped without a grant, except on rst.
- Counters: icnt and rcnt are clog2(LINE_WORDS)+1 bits wide and saturate at LINE_WORDS. Address arithmetic wraps modulo 2^ADDR_W.
- Boundary cases:
  - mem_rvalid in IDLE/WRITE/RESP, or in READ with rcnt==LINE_WORDS: data dropped, err←1.
  - mem_gnt while mem_req=0: ignored.
  - req_valid during WRITE/READ/RESP: not accepted (req_ready=0). In RESP with resp_ready=1 and req_valid=1 in the same cycle, the next request is accepted the following cycle.
  - rst mid-transaction aborts at that posedge; in-flight bus beats are forgotten and late rvalid after reset sets err.

Test Plan:
- Reset, then read from IDLE → req_ready=1, resp_valid=0, mem_req=0, err=0.
- Write-back: req_addr=0x0000_1238, data words {0x11,0x22,0x33,0x44}, gnt every cycle → beats at 0x1230/0x1234/0x1238/0x123C carrying 0x11/0x22/0x33/0x44; req_ready returns to 1 on the 5th cycle after accept.
- Fill: addr 0x8000_0040, rdata 0xA0..0xA3 one cycle after each grant → resp_valid on cycle 6, resp_data=0x000000A3_000000A2_000000A1_000000A0.
- Backpressure: mem_gnt low for 3 cycles on beat 2, resp_ready low for 5 cycles → mem_addr/mem_wdata stable while ungranted, resp_data stable, exactly 4 grants, single response.
- Stray mem_rvalid in IDLE → err=1 and stays 1 until rst; rst mid-fill (after 2 words) → IDLE next cycle, mem_req=0, req_ready=1.
- Back-to-back: fill completes with resp_ready=1 and req_valid held high (write) → write accepted the cycle after, first write beat the cycle after that.

Source files
------------

// File: rtl/dcache_mem_responder_if.sv
// Cache-line request/response bundle plus the word-bus side of the responder.
// Latency: none, this is wiring only.
// Backpressure: req_ready/resp_ready for lines, mem_gnt for word beats.
interface dcache_mem_responder_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
);
  // cache side
  logic                     req_valid;
  logic                     req_wen;
  logic [ADDR_W-1:0]        req_addr;
  logic [LINE_WORDS*32-1:0] req_data;
  logic                     req_ready;
  logic                     resp_valid;
  logic [LINE_WORDS*32-1:0] resp_data;
  logic                     resp_ready;
  // word-bus side
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [31:0]              mem_wdata;
  logic                     mem_gnt;
  logic                     mem_rvalid;
  logic [31:0]              mem_rdata;

  // responder view
  modport slave (
    input  req_valid, req_wen, req_addr, req_data, resp_ready,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_data,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // cache + word-bus view
  modport master (
    output req_valid, req_wen, req_addr, req_data, resp_ready,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_data,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// Serialises D-cache line write-backs/fills into 32-bit word-bus beats and regathers fill words into a line.
// Latency: first beat the cycle after accept; zero-wait write 4 cycles, fill response 6 cycles after accept.
// Backpressure: one line in flight (req_ready only in IDLE); beats held until mem_gnt; response held until resp_ready.
module dcache_mem_responder #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_mem_responder_if.slave bus,
  output logic                  err
);
  // counters hold 0..LINE_WORDS, so one bit more than the word index
  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam int IW = CW - 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            base;
  logic [CW-1:0]                icnt;   // beats granted
  logic [CW-1:0]                rcnt;   // words received
  logic [LINE_WORDS-1:0][31:0]  line;   // write-back data, then fill data
  logic                         rd_take;
  logic                         unused_addr_lsb;

  // the low nibble of the request address selects within the line and is discarded
  assign unused_addr_lsb = ^bus.req_addr[3:0];

  // a returned word is only stored while a fill is still expecting words
  assign rd_take = bus.mem_rvalid && (state == READ) && (rcnt < FULL);

  assign bus.mem_addr  = base + ADDR_W'({icnt, 2'b00});
  assign bus.mem_wdata = line[icnt[IW-1:0]];
  assign bus.resp_data = line;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and handshake outputs, all decoded from state/counters only
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_nxt = bus.req_wen ? WRITE : READ;
      end
      WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_gnt && icnt == LAST) state_nxt = IDLE;
      end
      READ: begin
        bus.mem_req = (icnt < FULL);
        if (rd_take && rcnt == LAST) state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // request latch, beat/word counters, fill gathering and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      icnt <= '0;
      rcnt <= '0;
      line <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        base <= {bus.req_addr[ADDR_W-1:4], 4'b0000};
        line <= bus.req_data;
        icnt <= '0;
        rcnt <= '0;
      end
      if (bus.mem_req && bus.mem_gnt && icnt < FULL) icnt <= icnt + CW'(1);
      if (rd_take) begin
        line[rcnt[IW-1:0]] <= bus.mem_rdata;
        rcnt               <= rcnt + CW'(1);
      end else if (bus.mem_rvalid) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: reset, write-back, fill, bus/response stalls, stray rvalid, reset abort, back-to-back.
// Latency: checks the zero-wait cycle counts (write 4, fill 6) directly.
// Backpressure: bench drives mem_gnt/resp_ready stalls and a one-cycle-latency read return.
module tb_dcache_mem_responder;
  logic clk;
  logic rst;
  logic err;
  logic auto_rd;   // bench returns read data one cycle after each read grant
  int   n_vec;
  int   n_bad;

  dcache_mem_responder_if #(.LINE_WORDS(4), .ADDR_W(32)) bus ();

  dcache_mem_responder #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    logic        g;
    logic [31:0] a;
    g = bus.mem_req && bus.mem_gnt && !bus.mem_we;
    a = bus.mem_addr;
    @(posedge clk);
    #1;
    if (auto_rd) begin
      bus.mem_rvalid = g;
      bus.mem_rdata  = g ? (32'h0000_00A0 + {28'd0, a[5:2]}) : 32'd0;
    end
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!bus.resp_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {127'd0, bus.resp_valid}, 128'd1);
  endtask

  task automatic request(input logic wen, input logic [31:0] addr, input logic [127:0] data);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_data  = data;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] line_exp;
    logic [31:0]  a_hold;
    int beats;
    int stall;
    int cyc;

    n_vec = 0;
    n_bad = 0;
    auto_rd        = 1'b1;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req_ready", {127'd0, bus.req_ready}, 128'd1);
    chk("rst_resp_valid", {127'd0, bus.resp_valid}, 128'd0);
    chk("rst_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_mem_addr", {96'd0, bus.mem_addr}, 128'd0);
    chk("rst_mem_wdata", {96'd0, bus.mem_wdata}, 128'd0);
    chk("rst_resp_data", bus.resp_data, 128'd0);

    // write-back, zero-wait bus
    bus.mem_gnt = 1'b1;
    request(1'b1, 32'h0000_1238, 128'h00000044_00000033_00000022_00000011);
    for (int k = 0; k < 4; k++) begin
      chk("wr_mem_req", {127'd0, bus.mem_req}, 128'd1);
      chk("wr_mem_we", {127'd0, bus.mem_we}, 128'd1);
      chk("wr_req_ready", {127'd0, bus.req_ready}, 128'd0);
      chk("wr_addr", {96'd0, bus.mem_addr}, {96'd0, 32'h0000_1230 + 32'(4 * k)});
      chk("wr_wdata", {96'd0, bus.mem_wdata}, {96'd0, 32'h11 * 32'(k + 1)});
      tick();
    end
    chk("wr_done_req_ready", {127'd0, bus.req_ready}, 128'd1);
    chk("wr_done_mem_req", {127'd0, bus.mem_req}, 128'd0);

    // line fill, zero-wait bus: resp_valid first in cycle 6
    request(1'b0, 32'h8000_0040, 128'd0);
    chk("rd_first_addr", {96'd0, bus.mem_addr}, {96'd0, 32'h8000_0040});
    chk("rd_first_we", {127'd0, bus.mem_we}, 128'd0);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("rd_resp_valid_c%0d", i), {127'd0, bus.resp_valid}, {127'd0, i == 6});
      if (i < 6) tick();
    end
    line_exp = 128'h000000A3_000000A2_000000A1_000000A0;
    chk("rd_resp_data", bus.resp_data, line_exp);
    chk("rd_resp_mem_req", {127'd0, bus.mem_req}, 128'd0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("rd_done_req_ready", {127'd0, bus.req_ready}, 128'd1);
    chk("rd_done_resp_valid", {127'd0, bus.resp_valid}, 128'd0);

    // write with grant withheld for 3 cycles on beat 2
    request(1'b1, 32'h0000_2000, 128'h000000B3_000000B2_000000B1_000000B0);
    beats = 0;
    stall = 0;
    cyc   = 1;
    while (!bus.req_ready && cyc < 30) begin
      bus.mem_gnt = !(beats == 2 && stall < 3);
      chk("bp_mem_req", {127'd0, bus.mem_req}, 128'd1);
      chk("bp_addr", {96'd0, bus.mem_addr}, {96'd0, 32'h0000_2000 + 32'(4 * beats)});
      chk("bp_wdata", {96'd0, bus.mem_wdata}, {96'd0, 32'hB0 + 32'(beats)});
      if (bus.mem_gnt) beats++;
      else stall++;
      tick();
      cyc++;
    end
    bus.mem_gnt = 1'b1;
    chk("bp_grants", 128'(beats), 128'd4);
    chk("bp_idle_cycle", 128'(cyc), 128'd8);

    // fill with resp_ready withheld for 5 cycles
    request(1'b0, 32'h0000_0044, 128'd0);
    wait_resp("bp_resp_timeout");
    line_exp = 128'h000000A3_000000A2_000000A1_000000A0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_held", {127'd0, bus.resp_valid}, 128'd1);
      chk("bp_resp_data", bus.resp_data, line_exp);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_single_resp", {127'd0, bus.resp_valid}, 128'd0);
      tick();
    end
    chk("bp_no_err", {127'd0, err}, 128'd0);

    // stray rvalid in IDLE: dropped, sticky error
    auto_rd        = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("stray_err", {127'd0, err}, 128'd1);
    tick();
    tick();
    chk("stray_err_sticky", {127'd0, err}, 128'd1);
    chk("stray_dropped", bus.resp_data, line_exp);
    auto_rd = 1'b1;

    // reset after two fill words have arrived; the in-flight word lands after reset
    request(1'b0, 32'h0000_0100, 128'd0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_req_ready", {127'd0, bus.req_ready}, 128'd1);
    chk("abort_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("abort_err_cleared", {127'd0, err}, 128'd0);
    chk("abort_late_rvalid", {127'd0, bus.mem_rvalid}, 128'd1);
    tick();
    chk("abort_late_err", {127'd0, err}, 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_clean", {127'd0, err}, 128'd0);

    // back-to-back: write held valid while the fill response is taken
    request(1'b0, 32'h0000_0300, 128'd0);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_wen    = 1'b1;
    bus.req_addr   = 32'h0000_0400;
    bus.req_data   = 128'h000000C3_000000C2_000000C1_000000C0;
    wait_resp("b2b_resp_timeout");
    chk("b2b_resp_data", bus.resp_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("b2b_busy_in_resp", {127'd0, bus.req_ready}, 128'd0);
    tick();
    chk("b2b_idle_ready", {127'd0, bus.req_ready}, 128'd1);
    chk("b2b_idle_no_req", {127'd0, bus.mem_req}, 128'd0);
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    a_hold = bus.mem_addr;
    chk("b2b_wr_req", {127'd0, bus.mem_req}, 128'd1);
    chk("b2b_wr_we", {127'd0, bus.mem_we}, 128'd1);
    chk("b2b_wr_addr", {96'd0, a_hold}, {96'd0, 32'h0000_0400});
    chk("b2b_wr_wdata", {96'd0, bus.mem_wdata}, {96'd0, 32'h0000_00C0});
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_wr_done", {127'd0, bus.req_ready}, 128'd1);
    chk("b2b_final_err", {127'd0, err}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
